keypad_scan_encoder: RTL and testbench



---
 rtl/keypad_scan_encoder_pkg.sv | 17 +
 rtl/keypad_scan_encoder_if.sv | 35 +++
 rtl/keypad_scan_encoder_key_prio_enc.sv | 29 ++
 rtl/keypad_scan_encoder.sv | 140 ++++++++++++++
 tb/tb_keypad_scan_encoder.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/keypad_scan_encoder_pkg.sv
// Shared keypad-entry definitions: FSM encodings and default sizing.
// Also used by the timer digit-entry logic.
package keypad_scan_encoder_pkg;

  localparam int DEF_NUM_KEYS        = 10;
  localparam int DEF_CODE_W          = 4;
  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_CNT_W           = 3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_t;

endpackage

// File: rtl/keypad_scan_encoder_if.sv
// Key bus and encoded-key result bundle between keypad front end
// and the timer digit-entry logic.
interface keypad_scan_encoder_if
  import keypad_scan_encoder_pkg::*;
#(
  parameter int NUM_KEYS = DEF_NUM_KEYS,
  parameter int CODE_W   = DEF_CODE_W
);

  logic                enable_n;
  logic [NUM_KEYS-1:0] keypad;
  logic [CODE_W-1:0]   code_out;
  logic                key_strobe;
  logic                key_held;
  logic                multi_key;

  modport master (
    output enable_n,
    output keypad,
    input  code_out,
    input  key_strobe,
    input  key_held,
    input  multi_key
  );

  modport slave (
    input  enable_n,
    input  keypad,
    output code_out,
    output key_strobe,
    output key_held,
    output multi_key
  );

endinterface

// File: rtl/keypad_scan_encoder_key_prio_enc.sv
// Combinational highest-index key encoder with a more-than-one-key flag.
// Code output is don't-care when no key is set.
module key_prio_enc
  import keypad_scan_encoder_pkg::*;
#(
  parameter int NUM_KEYS = DEF_NUM_KEYS,
  parameter int CODE_W   = DEF_CODE_W
) (
  input  logic [NUM_KEYS-1:0] keys,
  output logic [CODE_W-1:0]   code,
  output logic                multi
);

  logic seen;

  always_comb begin
    code  = '0;
    multi = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (keys[i]) begin
        if (seen) multi = 1'b1;
        seen = 1'b1;
        code = CODE_W'(i);
      end
    end
  end

endmodule

// File: rtl/keypad_scan_encoder.sv
// Synchronised, debounced keypad encoder: one strobe per accepted press,
// rollover lockout while held, multi-key flag captured at acceptance.
module keypad_scan_encoder
  import keypad_scan_encoder_pkg::*;
#(
  parameter int NUM_KEYS        = DEF_NUM_KEYS,
  parameter int CODE_W          = DEF_CODE_W,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  reset_n,
  keypad_scan_encoder_if.slave  bus
);

  logic [NUM_KEYS-1:0] sync1;
  logic [NUM_KEYS-1:0] keys_s;

  logic [CODE_W-1:0] enc_code;
  logic              enc_multi;
  logic              any_key;

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [CNT_W-1:0]  cnt_inc;
  logic              cnt_done;
  logic [CODE_W-1:0] cand, cand_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              strobe_q, strobe_d;
  logic              held_q, held_d;
  logic              multi_q, multi_d;

  key_prio_enc #(
    .NUM_KEYS (NUM_KEYS),
    .CODE_W   (CODE_W)
  ) u_enc (
    .keys  (keys_s),
    .code  (enc_code),
    .multi (enc_multi)
  );

  assign any_key  = |keys_s;
  assign cnt_inc  = cnt + CNT_W'(1);
  assign cnt_done = (cnt_inc == CNT_W'(DEBOUNCE_CYCLES));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1  <= '0;
      keys_s <= '0;
    end else begin
      sync1  <= bus.keypad;
      keys_s <= sync1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      cand     <= '0;
      code_q   <= '0;
      strobe_q <= 1'b0;
      held_q   <= 1'b0;
      multi_q  <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      cand     <= cand_d;
      code_q   <= code_d;
      strobe_q <= strobe_d;
      held_q   <= held_d;
      multi_q  <= multi_d;
    end
  end

  // Only DEBOUNCE->PRESSED strobes, so strobes can never be adjacent.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    cand_d   = cand;
    code_d   = code_q;
    strobe_d = 1'b0;
    held_d   = held_q;
    multi_d  = multi_q;
    if (bus.enable_n) begin
      state_d = IDLE;
      cnt_d   = '0;
      held_d  = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_key) begin
            state_d = DEBOUNCE;
            cnt_d   = CNT_W'(1);
            cand_d  = enc_code;
          end
        end
        DEBOUNCE: begin
          if (!any_key) begin
            state_d = IDLE;
          end else if (enc_code != cand) begin
            cand_d = enc_code;
            cnt_d  = CNT_W'(1);
          end else if (cnt_done) begin
            state_d  = PRESSED;
            code_d   = cand;
            strobe_d = 1'b1;
            held_d   = 1'b1;
            multi_d  = enc_multi;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        PRESSED: begin
          if (!any_key) begin
            state_d = RELEASE;
            cnt_d   = CNT_W'(1);
          end
        end
        RELEASE: begin
          if (any_key) begin
            state_d = PRESSED;
          end else if (cnt_done) begin
            state_d = IDLE;
            held_d  = 1'b0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.code_out   = code_q;
  assign bus.key_strobe = strobe_q;
  assign bus.key_held   = held_q;
  assign bus.multi_key  = multi_q;

endmodule

// File: tb/tb_keypad_scan_encoder.sv
// Directed bench for keypad_scan_encoder (NUM_KEYS=10, D=4).
// Inputs change after negedge; outputs sampled at negedge.
module tb_keypad_scan_encoder;

  logic clk;
  logic reset_n;
  int   errors;
  int   checks;

  keypad_scan_encoder_if #(.NUM_KEYS(10), .CODE_W(4)) bus ();

  keypad_scan_encoder #(
    .NUM_KEYS        (10),
    .CODE_W          (4),
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (3)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n      = 1'b0;
    bus.enable_n = 1'b0;
    bus.keypad   = '0;
    step();
    step();
    checks++;
    if ({bus.code_out, bus.key_strobe, bus.key_held, bus.multi_key} !== 7'd0) begin
      errors++;
      $display("FAIL reset_outs: got %0h want 0",
               {bus.code_out, bus.key_strobe, bus.key_held, bus.multi_key});
    end
    reset_n = 1'b1;
    step();
  endtask

  // Expects key_held high now; released keys drop key_held after edge 5.
  task automatic release_all(input string tag);
    bus.keypad = '0;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (bus.key_held !== (i < 5) || bus.key_strobe !== 1'b0) begin
        errors++;
        $display("FAIL %s_release edge%0d: held=%b strobe=%b want held=%b strobe=0",
                 tag, i, bus.key_held, bus.key_strobe, i < 5);
      end
    end
  endtask

  task automatic test_single_press();
    bus.keypad = 10'h080;
    for (int i = 0; i < 7; i++) begin
      step();
      checks++;
      if (bus.key_strobe !== (i == 5)) begin
        errors++;
        $display("FAIL t1_strobe edge%0d: got %b want %b", i, bus.key_strobe, i == 5);
      end
      if (i == 5) begin
        checks++;
        if (bus.code_out !== 4'd7 || bus.key_held !== 1'b1 || bus.multi_key !== 1'b0) begin
          errors++;
          $display("FAIL t1_outs: code=%0d held=%b multi=%b want 7 1 0",
                   bus.code_out, bus.key_held, bus.multi_key);
        end
      end
    end
    release_all("t1");
  endtask

  task automatic test_bounce();
    logic [9:0] pat [10];
    pat = '{10'h008, 10'h008, 10'h000, 10'h000, 10'h008,
            10'h008, 10'h000, 10'h000, 10'h000, 10'h000};
    for (int i = 0; i < 10; i++) begin
      bus.keypad = pat[i];
      step();
      checks++;
      if (bus.key_strobe !== 1'b0) begin
        errors++;
        $display("FAIL t2_bounce edge%0d: got %b want 0", i, bus.key_strobe);
      end
    end
    bus.keypad = 10'h008;
    for (int i = 0; i < 7; i++) begin
      step();
      checks++;
      if (bus.key_strobe !== (i == 5)) begin
        errors++;
        $display("FAIL t2_strobe edge%0d: got %b want %b", i, bus.key_strobe, i == 5);
      end
    end
    checks++;
    if (bus.code_out !== 4'd3) begin
      errors++;
      $display("FAIL t2_code: got %0d want 3", bus.code_out);
    end
    release_all("t2");
  endtask

  task automatic test_multi_rollover();
    bus.keypad = 10'h204;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (bus.key_strobe !== (i == 5)) begin
        errors++;
        $display("FAIL t3_strobe edge%0d: got %b want %b", i, bus.key_strobe, i == 5);
      end
    end
    checks++;
    if (bus.code_out !== 4'd9 || bus.multi_key !== 1'b1) begin
      errors++;
      $display("FAIL t3_multi: code=%0d multi=%b want 9 1", bus.code_out, bus.multi_key);
    end
    bus.keypad = 10'h004;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (bus.key_strobe !== 1'b0) begin
        errors++;
        $display("FAIL t3_lockout edge%0d: got %b want 0", i, bus.key_strobe);
      end
    end
    checks++;
    if (bus.code_out !== 4'd9 || bus.key_held !== 1'b1) begin
      errors++;
      $display("FAIL t3_hold: code=%0d held=%b want 9 1", bus.code_out, bus.key_held);
    end
    release_all("t3");
  endtask

  task automatic test_release_bounce();
    bus.keypad = 10'h020;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (bus.key_strobe !== (i == 5)) begin
        errors++;
        $display("FAIL t4_strobe edge%0d: got %b want %b", i, bus.key_strobe, i == 5);
      end
    end
    for (int i = 0; i < 10; i++) begin
      bus.keypad = (i == 2) ? 10'h020 : 10'h000;
      step();
      checks++;
      if (bus.key_held !== (i < 8) || bus.key_strobe !== 1'b0) begin
        errors++;
        $display("FAIL t4_glitch edge%0d: held=%b strobe=%b want held=%b strobe=0",
                 i, bus.key_held, bus.key_strobe, i < 8);
      end
    end
    bus.keypad = 10'h020;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (bus.key_strobe !== (i == 5)) begin
        errors++;
        $display("FAIL t4_repress edge%0d: got %b want %b", i, bus.key_strobe, i == 5);
      end
    end
    checks++;
    if (bus.code_out !== 4'd5) begin
      errors++;
      $display("FAIL t4_code: got %0d want 5", bus.code_out);
    end
    release_all("t4");
  endtask

  task automatic test_enable();
    bus.keypad = 10'h010;
    repeat (6) step();
    checks++;
    if (bus.code_out !== 4'd4 || bus.key_held !== 1'b1) begin
      errors++;
      $display("FAIL t5_press: code=%0d held=%b want 4 1", bus.code_out, bus.key_held);
    end
    bus.enable_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (bus.key_held !== 1'b0 || bus.key_strobe !== 1'b0 || bus.code_out !== 4'd4) begin
        errors++;
        $display("FAIL t5_disabled edge%0d: held=%b strobe=%b code=%0d want 0 0 4",
                 i, bus.key_held, bus.key_strobe, bus.code_out);
      end
    end
    bus.enable_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (bus.key_strobe !== (i == 3)) begin
        errors++;
        $display("FAIL t5_reenable edge%0d: got %b want %b", i, bus.key_strobe, i == 3);
      end
    end
    release_all("t5");
  endtask

  task automatic test_async_reset();
    bus.keypad = 10'h040;
    repeat (3) step();
    reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.code_out, bus.key_strobe, bus.key_held, bus.multi_key} !== 7'd0) begin
      errors++;
      $display("FAIL t6_rst_debounce: got %0h want 0",
               {bus.code_out, bus.key_strobe, bus.key_held, bus.multi_key});
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      checks++;
      if (bus.key_strobe !== (i == 5)) begin
        errors++;
        $display("FAIL t6_strobe_a edge%0d: got %b want %b", i, bus.key_strobe, i == 5);
      end
    end
    checks++;
    if (bus.code_out !== 4'd6 || bus.key_held !== 1'b1) begin
      errors++;
      $display("FAIL t6_code_a: code=%0d held=%b want 6 1", bus.code_out, bus.key_held);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.code_out, bus.key_strobe, bus.key_held, bus.multi_key} !== 7'd0) begin
      errors++;
      $display("FAIL t6_rst_pressed: got %0h want 0",
               {bus.code_out, bus.key_strobe, bus.key_held, bus.multi_key});
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      checks++;
      if (bus.key_strobe !== (i == 5)) begin
        errors++;
        $display("FAIL t6_strobe_b edge%0d: got %b want %b", i, bus.key_strobe, i == 5);
      end
    end
    release_all("t6");
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_single_press();
    test_bounce();
    test_multi_rollover();
    test_release_bounce();
    test_enable();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
